// File: rtl/mpuc_pkg.sv
// Shared types and helpers for the eighth-turn complex rotator.
// Coefficient generation and the quadrant swap/negate table live here.
package mpuc_pkg;

    typedef logic [2:0] rot_t;
    typedef logic signed [31:0] cval_t;

    typedef struct packed {
        cval_t re;
        cval_t im;
    } cpair_t;

    // Elaboration-time only: round(cos(pi/4) * 2^cb).
    function automatic int c707(input int cb);
        return $rtoi(0.70710678118654752 * (2.0 ** cb) + 0.5);
    endfunction

    // Multiply (x + jy) by (-j)^m.
    function automatic cpair_t quad_rot(input cval_t x, input cval_t y, input logic [1:0] m);
        cpair_t r;
        case (m)
            2'd0:    begin r.re = x;  r.im = y;  end
            2'd1:    begin r.re = y;  r.im = -x; end
            2'd2:    begin r.re = -x; r.im = -y; end
            default: begin r.re = -y; r.im = x;  end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mpuc_cmul_const.sv
// Signed operand times round(0.7071*2^CB), scaled by 2^-CB (floor, or round-half-up with MPUC_ROUND_EN).
// Latency: 1 ED edge; BYP passes the operand through unscaled with the same latency.
// Backpressure: none; ED=0 freezes the result register.
module mpuc_cmul_const
    import mpuc_pkg::*;
#(
    parameter int W1 = 17,
    parameter int CB = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ED,
    input  logic                 BYP,
    input  logic signed [W1-1:0] A,
    output logic signed [W1-1:0] P
);

    localparam int PW = W1 + CB + 2;
    localparam logic signed [PW-1:0] CK = PW'(c707(CB));
`ifdef MPUC_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (CB - 1);
`else
    localparam logic signed [PW-1:0] HALF = '0;
`endif

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] q;
    logic                 unused_hi;

    // The magnitude of q is below 2^(W1-1), so the upper bits are pure sign copies.
    always_comb begin
        prod = PW'(A) * CK;
        rnd  = prod + HALF;
        q    = rnd >>> CB;
    end

    assign unused_hi = ^q[PW-1:W1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            P <= '0;
        end else if (ED) begin
            P <= BYP ? A : q[W1-1:0];
        end
    end

endmodule

// File: rtl/mpuc_rot8.sv
// Complex rotator: (DR + jDI) * e^(-j*k*pi/4), k per sample; rounding mode via MPUC_ROUND_EN.
// Latency: result and RDY at ED edge n+3 for DS at ED edge n; one sample per 2 ED edges.
// Backpressure: none; DS during the second phase is dropped and sets sticky ERR.
module mpuc_rot8
    import mpuc_pkg::*;
#(
    parameter int W  = 16,
    parameter int CB = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ED,
    input  logic                DS,
    input  rot_t                ROT,
    input  logic signed [W-1:0] DR,
    input  logic signed [W-1:0] DI,
    output logic signed [W:0]   DOR,
    output logic signed [W:0]   DOI,
    output logic                RDY,
    output logic                ERR
);

    typedef enum logic {PH0, PH1} phase_t;

    phase_t            state;
    phase_t            state_nxt;
    logic              accept;
    logic              proto_err;
    logic signed [W-1:0] a_r;
    logic signed [W-1:0] b_r;
    rot_t              k_r;
    logic [1:0]        m_mul;
    logic [1:0]        m_x;
    logic signed [W:0] op_nxt;
    logic signed [W:0] op_q;
    logic              byp_nxt;
    logic              byp_q;
    logic signed [W:0] mul_p;
    logic signed [W:0] x_q;
    logic              v_mul;
    logic              v_x;
    cpair_t            rot_res;
    logic              unused_rot;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= PH0;
        end else if (ED) begin
            state <= state_nxt;
        end
    end

    // Phase 0 feeds s (or a) straight from the inputs; phase 1 feeds d (or b) from the held sample.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        proto_err = 1'b0;
        op_nxt    = '0;
        byp_nxt   = 1'b1;
        case (state)
            PH0: begin
                accept  = DS;
                byp_nxt = ~ROT[0];
                op_nxt  = ROT[0] ? ((W+1)'(DR) + (W+1)'(DI)) : (W+1)'(DR);
                if (DS) state_nxt = PH1;
            end
            PH1: begin
                proto_err = DS;
                byp_nxt   = ~k_r[0];
                op_nxt    = k_r[0] ? ((W+1)'(b_r) - (W+1)'(a_r)) : (W+1)'(b_r);
                state_nxt = PH0;
            end
            default: state_nxt = PH0;
        endcase
    end

    mpuc_cmul_const #(
        .W1 (W + 1),
        .CB (CB)
    ) u_cmul (
        .CLK (CLK),
        .RST (RST),
        .ED  (ED),
        .BYP (byp_q),
        .A   (op_q),
        .P   (mul_p)
    );

    assign rot_res    = quad_rot(cval_t'(x_q), cval_t'(mul_p), m_x);
    assign unused_rot = ^{rot_res.re[31:W+1], rot_res.im[31:W+1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r   <= '0;
            b_r   <= '0;
            k_r   <= '0;
            m_mul <= '0;
            m_x   <= '0;
            op_q  <= '0;
            byp_q <= 1'b1;
            x_q   <= '0;
            v_mul <= 1'b0;
            v_x   <= 1'b0;
            DOR   <= '0;
            DOI   <= '0;
            RDY   <= 1'b0;
            ERR   <= 1'b0;
        end else if (ED) begin
            if (accept) begin
                a_r <= DR;
                b_r <= DI;
                k_r <= ROT;
            end
            if (proto_err) ERR <= 1'b1;
            op_q  <= op_nxt;
            byp_q <= byp_nxt;
            // k_r is stable for two edges after accept, so a free-running delay line tracks the sample.
            m_mul <= k_r[2:1];
            m_x   <= m_mul;
            v_mul <= (state == PH1);
            v_x   <= v_mul;
            if (v_mul) x_q <= mul_p;
            RDY <= v_x;
            if (v_x) begin
                DOR <= rot_res.re[W:0];
                DOI <= rot_res.im[W:0];
            end
        end
    end

endmodule

// File: tb/tb_mpuc_rot8.sv
// Bench for mpuc_rot8: directed literal cases plus randomized ED/DS/RST traffic against a reference model.
module tb_mpuc_rot8;

    localparam int W  = 16;
    localparam int CB = 16;
    localparam longint C = 46341;
`ifdef MPUC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic                ED;
    logic                DS;
    logic [2:0]          ROT;
    logic signed [W-1:0] DR;
    logic signed [W-1:0] DI;
    logic signed [W:0]   DOR;
    logic signed [W:0]   DOI;
    logic                RDY;
    logic                ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mpuc_rot8 #(.W(W), .CB(CB)) dut (
        .CLK (CLK),
        .RST (RST),
        .ED  (ED),
        .DS  (DS),
        .ROT (ROT),
        .DR  (DR),
        .DI  (DI),
        .DOR (DOR),
        .DOI (DOI),
        .RDY (RDY),
        .ERR (ERR)
    );

    typedef struct {
        int     due;
        longint re;
        longint im;
    } pend_t;

    pend_t  pq[$];
    int     ed_cnt   = 0;
    int     last_acc = -10;
    bit     model_on = 1'b0;
    bit     m_err    = 1'b0;
    bit     m_rdy    = 1'b0;
    longint m_re     = 0;
    longint m_im     = 0;
    longint g_re;
    longint g_im;

    function automatic longint qf(input longint p);
        longint den = longint'(1) << CB;
        longint n   = RND ? p + den / 2 : p;
        longint q   = n / den;
        if (n < 0 && (n % den) != 0) q = q - 1;
        return q;
    endfunction

    function automatic void golden(input logic [2:0] k, input longint a, input longint b,
                                   output longint re, output longint im);
        longint x;
        longint y;
        if (k[0]) begin
            x = qf((a + b) * C);
            y = qf((b - a) * C);
        end else begin
            x = a;
            y = b;
        end
        case (k[2:1])
            2'd0:    begin re = x;  im = y;  end
            2'd1:    begin re = y;  im = -x; end
            2'd2:    begin re = -x; im = -y; end
            default: begin re = -y; im = x;  end
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model advances on every ED edge; outputs compared just after every edge.
    always @(posedge CLK) begin
        if (RST) begin
            pq.delete();
            m_err    = 1'b0;
            m_rdy    = 1'b0;
            m_re     = 0;
            m_im     = 0;
            last_acc = -10;
            ed_cnt   = 0;
            model_on = 1'b1;
        end else if (ED && model_on) begin
            ed_cnt++;
            if (DS) begin
                if (last_acc == ed_cnt - 1) begin
                    m_err = 1'b1;
                end else begin
                    golden(ROT, DR, DI, g_re, g_im);
                    pq.push_back('{ed_cnt + 3, g_re, g_im});
                    last_acc = ed_cnt;
                end
            end
            m_rdy = 1'b0;
            if (pq.size() > 0 && pq[0].due == ed_cnt) begin
                m_rdy = 1'b1;
                m_re  = pq[0].re;
                m_im  = pq[0].im;
                void'(pq.pop_front());
            end
        end
        #1;
        if (model_on) begin
            check("model_rdy", longint'(RDY), longint'(m_rdy));
            check("model_err", longint'(ERR), longint'(m_err));
            check("model_dor", longint'(DOR), m_re);
            check("model_doi", longint'(DOI), m_im);
        end
    end

    task automatic send(input logic [2:0] k, input int a, input int b);
        @(negedge CLK);
        DS  = 1'b1;
        ROT = k;
        DR  = a[W-1:0];
        DI  = b[W-1:0];
        @(negedge CLK);
        DS  = 1'b0;
    endtask

    // Checks the output exactly at ED edge n+3 and that RDY drops one edge later.
    task automatic send_expect(input string name, input logic [2:0] k, input int a, input int b,
                               input longint er, input longint ei);
        send(k, a, b);
        repeat (3) @(posedge CLK);
        #2;
        check({name, "_rdy"}, longint'(RDY), 1);
        check({name, "_dor"}, longint'(DOR), er);
        check({name, "_doi"}, longint'(DOI), ei);
        @(posedge CLK);
        #2;
        check({name, "_rdy_drop"}, longint'(RDY), 0);
    endtask

    initial begin
        RST = 1'b1;
        ED  = 1'b1;
        DS  = 1'b0;
        ROT = '0;
        DR  = '0;
        DI  = '0;
        repeat (3) @(negedge CLK);
        check("reset_dor", longint'(DOR), 0);
        check("reset_doi", longint'(DOI), 0);
        check("reset_rdy", longint'(RDY), 0);
        check("reset_err", longint'(ERR), 0);
        RST = 1'b0;

        send_expect("k0", 3'd0, 1000, -2000, 1000, -2000);
        send_expect("k1", 3'd1, 10000, 0, 7071, RND ? -7071 : -7072);
        send_expect("k2", 3'd2, -32768, 5, 5, 32768);
        send_expect("k7", 3'd7, 32767, 32767, 0, RND ? 46340 : 46339);

        // Back-to-back DS: second one dropped, then legal spacing resumes.
        @(negedge CLK); DS = 1'b1; ROT = 3'd3; DR = 16'sd1234; DI = -16'sd777;
        @(negedge CLK); DS = 1'b1; ROT = 3'd0; DR = 16'sd5;    DI = 16'sd5;
        @(negedge CLK); DS = 1'b1; ROT = 3'd6; DR = 16'sd100;  DI = 16'sd200;
        @(negedge CLK); DS = 1'b0;
        @(posedge CLK); #2;
        check("err_first_rdy", longint'(RDY), 1);
        check("err_first_dor", longint'(DOR), -1422);
        check("err_first_doi", longint'(DOI), -323);
        check("err_flag", longint'(ERR), 1);
        @(negedge CLK); DS = 1'b1; ROT = 3'd1; DR = -16'sd3000; DI = 16'sd4000;
        @(negedge CLK); DS = 1'b0;
        repeat (6) @(negedge CLK);
        check("err_sticky", longint'(ERR), 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("err_cleared", longint'(ERR), 0);

        // Reset one edge after an accepted sample discards it.
        send(3'd5, 12345, -321);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #2;
            check("rst_no_late_rdy", longint'(RDY), 0);
        end
        check("rst_dor", longint'(DOR), 0);
        check("rst_doi", longint'(DOI), 0);

        // ED alternating with random traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            ED  = (i % 2 == 0);
            DS  = ($urandom_range(0, 2) == 0);
            ROT = 3'($urandom);
            DR  = ($urandom_range(0, 7) == 0) ? -16'sd32768 : W'($urandom);
            DI  = ($urandom_range(0, 7) == 0) ? 16'sd32767 : W'($urandom);
        end

        // Fully random ED/DS/RST, including reset while ED is low.
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            ED  = ($urandom_range(0, 3) != 0);
            DS  = ($urandom_range(0, 1) == 0);
            RST = ($urandom_range(0, 63) == 0);
            ROT = 3'($urandom);
            DR  = W'($urandom);
            DI  = W'($urandom);
        end

        @(negedge CLK);
        RST = 1'b0;
        ED  = 1'b1;
        DS  = 1'b0;
        repeat (10) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpuc_rot8.md
# mpuc_rot8

Parametrised complex rotator for FFT butterfly stages. Multiplies each complex sample (DR + jDI) by e^(-j·k·π/4), k = 0..7, selected per sample. Odd k uses a time-shared 0.7071 constant multiplier; quadrant factors (-j)^m are applied by swap/negate. It replaces the fixed 45°/-j multiplier in pipelined FFT datapaths and adds reset, per-sample rotation, a valid strobe, protocol-error flagging and an optional rounding mode.

## Interface
- W, 16: input component width (signed two's complement)
- CB, 16: coefficient fraction bits; C = round(0.70710678·2^CB) (46341 for CB=16)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high; overrides ED
- ED  in  1  clock enable (slowdown); all state advances only on edges where ED=1 ("ED edges")
- DS  in  1  data strobe; DR/DI/ROT sampled at an ED edge with DS=1
- ROT  in  3  rotation index k
- DR, DI  in  W  signed input real/imag
- DOR, DOI  out  W+1  signed rotated real/imag, registered
- RDY  out  1  result valid, registered
- ERR  out  1  sticky protocol error

## Operation
- Let a=DR, b=DI, m=k[2:1]. Base pair (x,y):
  - k even: x=a, y=b (sign-extended to W+1).
  - k odd: s=a+b, d=b−a (W+1 bits); x=Q(s·C), y=Q(d·C).
- Q(p)=floor(p/2^CB) (arithmetic shift). See Configuration for rounding.
- Output by m:
  - 0: (x, y)
  - 1: (y, −x)
  - 2: (−x, −y)
  - 3: (−y, x)
- W+1 output bits cannot overflow: even-k negation of −2^(W−1) fits; |Q| < 2^W.
- Shift-add or any multiplier structure is permitted; results must be bit-exact to the formulas above.
- Two-phase serial multiplier. DS at ED edge n:
  - phase 0 at n: s loaded.
  - phase 1 at n+1: d loaded.
  - Even k uses the same path and latency; the multiply result is bypassed.
- DS at an ED edge where the multiplier is in phase 1 (i.e. one ED edge after an accepted DS):
  - DS is ignored and ERR is set.
  - The in-flight sample completes correctly.
- ERR stays set until RST.

## Timing
- Latency: DOR/DOI update and RDY=1 at ED edge n+3 for DS accepted at edge n.
- RDY clears at the next ED edge unless another result lands there.
- Throughput: one sample per 2 ED edges (DS at n, n+2, n+4… gives RDY at n+3, n+5…).
- ED=0 freezes all registers; RDY, DOR and DOI hold. Consumers qualify RDY with ED.
- Reset values: DOR=0, DOI=0, RDY=0, ERR=0; phase and pipeline valids cleared.
- RST mid-operation discards all pending samples; no RDY is produced for them.
- RST with DS in the same cycle: RST wins and DS is ignored.
- RST must be honoured regardless of ED.

## Configuration
- MPUC_ROUND_EN defined: Q(p)=floor((p+2^(CB−1))/2^CB) (round half up).
- MPUC_ROUND_EN undefined: truncation (floor).
- Latency and interface are identical in both builds.

## Structure
- Package mpuc_pkg:
  - function c707(CB) returning the rounded coefficient
  - typedef for 3-bit rotation index
  - function quad_rot(x,y,m) implementing the swap/negate table
- One sub-module, mpuc_cmul_const: pipelined signed (W+1)×constant multiplier, one stage, with the Q() scaling and the MPUC_ROUND_EN option.
- The top level holds the phase FSM, the s/d mux, the x holding register, the k/valid delay line and the output stage.

## Test plan
All cases use W=16 and CB=16.
- k=0, DR=1000, DI=−2000, ED=1 → at edge n+3: DOR=1000, DOI=−2000, RDY=1 for one edge.
- k=1, DR=10000, DI=0 → DOR=7071, DOI=−7072 (truncate); DOI=−7071 with MPUC_ROUND_EN.
- k=2, DR=−32768, DI=5 → DOR=5, DOI=32768 (no overflow).
- k=7, DR=DI=32767 → DOR=0, DOI=46339 (truncate) / 46340 (round).
- DS on edges n and n+1 → sample n correct, second ignored, ERR=1. Then DS on n+2 and n+4 → RDY at n+5 and n+7, values correct.
- ED alternating 1/0 with random k/data → results match the golden model in ED-edge time; RDY held while ED=0. RST asserted at edge n+1 → DOR=DOI=0, RDY=0, ERR=0, no late RDY.
